turbo_deframer: RTL and testbench



---
 rtl/turbo_deframer_if.sv | 33 +++
 rtl/turbo_deframer.sv | 184 ++++++++++++++++++
 tb/tb_turbo_deframer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/turbo_deframer_if.sv
// Symbol stream and framing status bundle between the channel side and the deframer.
// The master drives symbols and observes status; the slave is the deframer itself.
interface turbo_deframer_if;
  logic        length_flag;
  logic        in_valid;
  logic        in_sys;
  logic        in_p1;
  logic        in_p2;
  logic        out_valid;
  logic        out_sys;
  logic        out_p1;
  logic        out_p2;
  logic [12:0] out_index;
  logic        out_last;
  logic [11:0] tail_bits;
  logic        tail_valid;
  logic        block_done;
  logic        busy;
  logic        err_gap;
  logic [7:0]  err_count;

  modport master (
    output length_flag, in_valid, in_sys, in_p1, in_p2,
    input  out_valid, out_sys, out_p1, out_p2, out_index, out_last,
    input  tail_bits, tail_valid, block_done, busy, err_gap, err_count
  );

  modport slave (
    input  length_flag, in_valid, in_sys, in_p1, in_p2,
    output out_valid, out_sys, out_p1, out_p2, out_index, out_last,
    output tail_bits, tail_valid, block_done, busy, err_gap, err_count
  );
endinterface

// File: rtl/turbo_deframer.sv
// Receive-side framing controller: forwards K data symbols with their index, captures
// the 4 trellis-termination symbols and flags blocks broken by a gap in the stream.
module turbo_deframer #(
  parameter int K_SHORT  = 1000,
  parameter int K_LONG   = 6000,
  parameter int TAIL_LEN = 4
) (
  input  logic            clk,
  input  logic            reset,
  turbo_deframer_if.slave bus
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  DATA      = 2'd3;
  localparam logic [1:0]  TAIL      = 2'd2;
  localparam logic [12:0] K_SHORT_W = 13'(K_SHORT);
  localparam logic [12:0] K_LONG_W  = 13'(K_LONG);
  localparam logic [12:0] TAIL_LAST = 13'(TAIL_LEN - 1);

  logic [1:0]  state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [12:0] k_q, k_d;
  logic [11:0] tsr_q, tsr_d;
  logic        ov_q, ov_d;
  logic        sys_q, sys_d;
  logic        p1_q, p1_d;
  logic        p2_q, p2_d;
  logic [12:0] idx_q, idx_d;
  logic        last_q, last_d;
  logic [11:0] tb_q, tb_d;
  logic        tv_q, tv_d;
  logic        bd_q, bd_d;
  logic        busy_q, busy_d;
  logic        eg_q, eg_d;
  logic [7:0]  ec_q, ec_d;

  logic [2:0]  sym;
  logic [12:0] k_sel;
  logic        abort;

  assign sym   = {bus.in_sys, bus.in_p1, bus.in_p2};
  assign k_sel = bus.length_flag ? K_LONG_W : K_SHORT_W;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    tsr_d   = tsr_q;
    ov_d    = 1'b0;
    sys_d   = sys_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    idx_d   = idx_q;
    last_d  = 1'b0;
    tb_d    = tb_q;
    tv_d    = 1'b0;
    bd_d    = 1'b0;
    eg_d    = 1'b0;
    ec_d    = ec_q;
    abort   = 1'b0;

    case (state_q)
      IDLE: begin
        // The symbol that opens a block is already data symbol 0.
        if (bus.in_valid) begin
          k_d   = k_sel;
          ov_d  = 1'b1;
          sys_d = sym[2];
          p1_d  = sym[1];
          p2_d  = sym[0];
          idx_d = 13'd0;
          if (k_sel == 13'd1) begin
            last_d  = 1'b1;
            cnt_d   = 13'd0;
            state_d = TAIL;
          end else begin
            cnt_d   = 13'd1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bus.in_valid) begin
          ov_d  = 1'b1;
          sys_d = sym[2];
          p1_d  = sym[1];
          p2_d  = sym[0];
          idx_d = cnt_q;
          if (cnt_q == k_q - 13'd1) begin
            last_d  = 1'b1;
            cnt_d   = 13'd0;
            state_d = TAIL;
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end else begin
          abort = 1'b1;
        end
      end
      TAIL: begin
        // Oldest tail symbol ends up in the top triple after the final shift.
        if (bus.in_valid) begin
          tsr_d = {tsr_q[8:0], sym};
          if (cnt_q == TAIL_LAST) begin
            tb_d    = {tsr_q[8:0], sym};
            tv_d    = 1'b1;
            bd_d    = 1'b1;
            cnt_d   = 13'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end else begin
          abort = 1'b1;
        end
      end
      default: begin
        cnt_d   = 13'd0;
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      eg_d    = 1'b1;
      ec_d    = (ec_q == 8'hFF) ? ec_q : ec_q + 8'd1;
      cnt_d   = 13'd0;
      state_d = IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      tsr_q   <= '0;
      ov_q    <= 1'b0;
      sys_q   <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      tb_q    <= '0;
      tv_q    <= 1'b0;
      bd_q    <= 1'b0;
      busy_q  <= 1'b0;
      eg_q    <= 1'b0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      tsr_q   <= tsr_d;
      ov_q    <= ov_d;
      sys_q   <= sys_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      tb_q    <= tb_d;
      tv_q    <= tv_d;
      bd_q    <= bd_d;
      busy_q  <= busy_d;
      eg_q    <= eg_d;
      ec_q    <= ec_d;
    end
  end

  assign bus.out_valid  = ov_q;
  assign bus.out_sys    = sys_q;
  assign bus.out_p1     = p1_q;
  assign bus.out_p2     = p2_q;
  assign bus.out_index  = idx_q;
  assign bus.out_last   = last_q;
  assign bus.tail_bits  = tb_q;
  assign bus.tail_valid = tv_q;
  assign bus.block_done = bd_q;
  assign bus.busy       = busy_q;
  assign bus.err_gap    = eg_q;
  assign bus.err_count  = ec_q;

endmodule

// File: tb/tb_turbo_deframer.sv
// Bench for turbo_deframer: the stimulus side queues the expected registered outputs
// for every driven cycle, and a negedge monitor pops and compares them.
module tb_turbo_deframer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  turbo_deframer_if bus();

  turbo_deframer #(.K_SHORT(1000), .K_LONG(6000), .TAIL_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit        ov;
    bit        sys;
    bit        p1;
    bit        p2;
    bit [12:0] idx;
    bit        last;
    bit        tv;
    bit        bd;
    bit        busy;
    bit        eg;
    bit [7:0]  ec;
    bit [11:0] tb;
  } exp_t;

  typedef struct {
    bit        lf;
    int        gap_at;
    int        toggle_at;
    bit [11:0] tail;
    int        exp_nov;
    int        exp_done;
    int        exp_ec;
    int        exp_last_idx;
    bit [11:0] exp_tb;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  bit   mon_bad;
  int   checks = 0;
  int   errors = 0;
  int   n_ov, n_done, n_tv, n_eg, n_last, last_idx;
  bit [7:0]  cur_ec;
  bit [11:0] cur_tb;

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      mon_bad = (bus.out_valid !== mon_e.ov) || (bus.out_last !== mon_e.last) ||
                (bus.tail_valid !== mon_e.tv) || (bus.block_done !== mon_e.bd) ||
                (bus.busy !== mon_e.busy) || (bus.err_gap !== mon_e.eg) ||
                (bus.err_count !== mon_e.ec) || (bus.tail_bits !== mon_e.tb);
      if (mon_e.ov)
        mon_bad = mon_bad || (bus.out_index !== mon_e.idx) || (bus.out_sys !== mon_e.sys) ||
                  (bus.out_p1 !== mon_e.p1) || (bus.out_p2 !== mon_e.p2);
      checks++;
      if (mon_bad) begin
        errors++;
        $display("FAIL sb_cycle t=%0t actual ov=%b idx=%0d sym=%b%b%b last=%b tv=%b bd=%b busy=%b eg=%b ec=%0d tb=%h required ov=%b idx=%0d sym=%b%b%b last=%b tv=%b bd=%b busy=%b eg=%b ec=%0d tb=%h",
                 $time, bus.out_valid, bus.out_index, bus.out_sys, bus.out_p1, bus.out_p2,
                 bus.out_last, bus.tail_valid, bus.block_done, bus.busy, bus.err_gap,
                 bus.err_count, bus.tail_bits, mon_e.ov, mon_e.idx, mon_e.sys, mon_e.p1,
                 mon_e.p2, mon_e.last, mon_e.tv, mon_e.bd, mon_e.busy, mon_e.eg, mon_e.ec,
                 mon_e.tb);
      end
    end
    if (bus.out_valid === 1'b1)  n_ov++;
    if (bus.block_done === 1'b1) n_done++;
    if (bus.tail_valid === 1'b1) n_tv++;
    if (bus.err_gap === 1'b1)    n_eg++;
    if (bus.out_last === 1'b1) begin
      n_last++;
      last_idx = int'(bus.out_index);
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_counts();
    n_ov = 0; n_done = 0; n_tv = 0; n_eg = 0; n_last = 0; last_idx = -1;
  endtask

  function automatic exp_t base();
    exp_t e;
    e = '{default: '0};
    e.ec = cur_ec;
    e.tb = cur_tb;
    return e;
  endfunction

  task automatic send(input bit v, input bit [2:0] sym, input bit lf, input exp_t e);
    @(negedge clk);
    #1;
    bus.in_valid    = v;
    bus.in_sys      = sym[2];
    bus.in_p1       = sym[1];
    bus.in_p2       = sym[0];
    bus.length_flag = lf;
    sbq.push_back(e);
  endtask

  task automatic idle();
    send(1'b0, 3'b000, 1'b0, base());
  endtask

  task automatic gap();
    exp_t e;
    cur_ec = (cur_ec == 8'd255) ? 8'd255 : cur_ec + 8'd1;
    e = base();
    e.eg = 1'b1;
    send(1'b0, 3'($urandom), 1'b0, e);
  endtask

  task automatic data_sym(input int i, input int k, input bit lf);
    exp_t e;
    bit [2:0] sym;
    sym = {i[0], 2'($urandom)};
    e = base();
    e.ov = 1'b1; e.sys = sym[2]; e.p1 = sym[1]; e.p2 = sym[0];
    e.idx = 13'(i); e.last = (i == k - 1); e.busy = 1'b1;
    send(1'b1, sym, lf, e);
  endtask

  task automatic run_block(input bit lf, input int gap_at, input int toggle_at,
                           input bit [11:0] tail);
    int k;
    int t;
    exp_t e;
    k = lf ? 6000 : 1000;
    for (int i = 0; i < k + 4; i++) begin
      if (i == gap_at) begin
        gap();
        return;
      end
      if (i < k) begin
        data_sym(i, k, (toggle_at >= 0 && i >= toggle_at) ? ~lf : lf);
      end else begin
        t = i - k;
        if (t == 3) cur_tb = tail;
        e = base();
        e.tv = (t == 3); e.bd = (t == 3); e.busy = (t != 3);
        send(1'b1, tail[11-3*t -: 3], lf, e);
      end
    end
  endtask

  task automatic flush();
    @(negedge clk);
    #1;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b0, -1,   -1,  12'hAF0, 1000, 1, 0, 999,  12'hAF0};
    vecs[1] = '{1'b1, -1,   500, 12'h5A3, 6000, 1, 0, 5999, 12'h5A3};
    vecs[2] = '{1'b0, 400,  -1,  12'h123, 400,  0, 1, -1,   12'h5A3};
    vecs[3] = '{1'b0, 1002, -1,  12'hFFF, 1000, 0, 2, 999,  12'h5A3};

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_sys = 1'b0; bus.in_p1 = 1'b0; bus.in_p2 = 1'b0;
    bus.length_flag = 1'b0;
    cur_ec = '0; cur_tb = '0;
    clear_counts();
    repeat (3) @(negedge clk);
    check("rst_out_valid",  int'(bus.out_valid),  0);
    check("rst_out_index",  int'(bus.out_index),  0);
    check("rst_out_last",   int'(bus.out_last),   0);
    check("rst_tail_bits",  int'(bus.tail_bits),  0);
    check("rst_tail_valid", int'(bus.tail_valid), 0);
    check("rst_busy",       int'(bus.busy),       0);
    check("rst_err_count",  int'(bus.err_count),  0);
    #1 reset = 1'b1;
    idle();

    for (int v = 0; v < 4; v++) begin
      clear_counts();
      run_block(vecs[v].lf, vecs[v].gap_at, vecs[v].toggle_at, vecs[v].tail);
      idle();
      idle();
      flush();
      check($sformatf("v%0d_n_out_valid", v),  n_ov,   vecs[v].exp_nov);
      check($sformatf("v%0d_n_block_done", v), n_done, vecs[v].exp_done);
      check($sformatf("v%0d_n_tail_valid", v), n_tv,   vecs[v].exp_done);
      check($sformatf("v%0d_err_count", v),    int'(bus.err_count), vecs[v].exp_ec);
      check($sformatf("v%0d_tail_bits", v),    int'(bus.tail_bits), int'(vecs[v].exp_tb));
      if (vecs[v].exp_last_idx < 0) begin
        check($sformatf("v%0d_n_last", v), n_last, 0);
      end else begin
        check($sformatf("v%0d_n_last", v),   n_last,   1);
        check($sformatf("v%0d_last_idx", v), last_idx, vecs[v].exp_last_idx);
      end
    end

    // Asynchronous reset between edges in the middle of a data run.
    for (int i = 0; i < 10; i++) data_sym(i, 1000, 1'b0);
    flush();
    check("pre_rst_busy", int'(bus.busy), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_out_index", int'(bus.out_index), 0);
    check("arst_busy",      int'(bus.busy),      0);
    check("arst_tail_bits", int'(bus.tail_bits), 0);
    check("arst_err_count", int'(bus.err_count), 0);
    check("arst_err_gap",   int'(bus.err_gap),   0);
    @(negedge clk);
    #1 reset = 1'b1;
    cur_ec = '0; cur_tb = '0;

    clear_counts();
    run_block(1'b0, -1, -1, 12'h3C5);
    idle();
    flush();
    check("restart_n_out_valid", n_ov, 1000);
    check("restart_tail_bits", int'(bus.tail_bits), 12'h3C5);

    // Back-to-back blocks: no idle cycle between them.
    clear_counts();
    run_block(1'b0, -1, -1, 12'h111);
    run_block(1'b0, -1, -1, 12'h222);
    idle();
    flush();
    check("b2b_n_block_done", n_done, 2);
    check("b2b_n_out_valid",  n_ov,   2000);
    check("b2b_err_count",    int'(bus.err_count), 0);
    check("b2b_tail_bits",    int'(bus.tail_bits), 12'h222);

    // Error counter saturation.
    clear_counts();
    for (int a = 0; a < 260; a++) begin
      data_sym(0, 1000, 1'b0);
      gap();
    end
    idle();
    flush();
    check("sat_err_count", int'(bus.err_count), 255);
    check("sat_n_err_gap", n_eg, 260);
    check("sat_n_tail_valid", n_tv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
